issue_hazard_ctrl: RTL and testbench
====================================

Name: issue_hazard_ctrl

Overview:
Issue controller between fetch and execute in the 2.5-stage RV32I pipeline. Decodes opcode, rd, rs1 and rs2 from the fetched word, keeps a register scoreboard for outstanding variable-latency loads, and stalls issue on RAW/WAW hazards or load-queue full. Flushes the wrong-path fetch slot on a taken-branch redirect from execute. Drives the registered issue slot (instruction plus decoded fields) into execute.

Parameters:
MAX_LOADS, 2, max outstanding loads (1..7); counter width 3 bits.
XLEN, 32, instruction width; fixed at 32.

Ports:
clk  in  1  clock, rising edge.
reset  in  1  asynchronous, active-high reset.
if_valid  in  1  fetch presents if_instr.
if_instr  in  32  fetched instruction word.
if_ready  out  1  combinational; fetch word accepted when if_valid && if_ready.
redirect  in  1  execute resolved a taken branch/jump this cycle.
wb_valid  in  1  load data returning this cycle.
wb_rd  in  5  destination register of the returning load.
ex_valid  out  1  issue slot holds a valid instruction.
ex_instr  out  32  registered instruction.
ex_opcode  out  7  ex_instr[6:0].
ex_rd  out  5  ex_instr[11:7].
ex_funct3  out  3  ex_instr[14:12].
ex_rs1  out  5  ex_instr[19:15].
ex_rs2  out  5  ex_instr[24:20].
ex_funct7  out  7  ex_instr[31:25].
stall  out  1  if_valid && !if_ready (debug/perf).

Behaviour:
- Reset (async): ex_valid=0, ex_instr and all ex_* fields=0, scoreboard pending[31:0]=0, load_cnt=0, state=RUN.
- Source use by opcode: rs1 unused for LUI 0110111, AUIPC 0010111, JAL 1101111. rs2 used only for R 0110011, S 0100011, B 1100011. Instruction is a load iff opcode 0000011.
- Bypass: pend_eff(r) = pending[r] && !(wb_valid && wb_rd==r). The register file is write-first.
- hazard = (rs1 used && pend_eff(rs1)) || (rs2 used && pend_eff(rs2)) || (rd!=0 && pend_eff(rd) && rd written) || (is_load && load_cnt==MAX_LOADS && !wb_valid).
- if_ready = (state!=FLUSH) && !redirect && !hazard.
- Issue: on accept, the next edge sets ex_valid=1 and registers ex_instr and the fields. Latency is 1 cycle.
- No accept: the next edge sets ex_valid=0 (bubble). The slot is never held, because execute never back-pressures.
- Scoreboard: an accepted load with rd!=0 sets pending[rd]. wb_valid clears pending[wb_rd]. If set and clear hit the same rd in one cycle, set wins. pending[0] is always 0.
- load_cnt: +1 on accepted load (including rd=0), -1 on wb_valid, net 0 when both occur. wb_valid with load_cnt==0 is illegal; the counter holds at 0.
- FSM:
  - RUN: if redirect -> FLUSH; else if if_valid && hazard -> HAZARD; else stay.
  - HAZARD: if redirect -> FLUSH; else if !hazard -> RUN. Acceptance in this state follows if_ready, so the instruction issues in the same cycle the hazard clears.
  - FLUSH: lasts exactly 1 cycle with if_ready=0 while fetch refills, then -> RUN. A redirect during FLUSH re-enters FLUSH.
- Redirect: the wrong-path word in the fetch slot is not accepted and no scoreboard bit is set for it. Outstanding loads stay pending because they are older and committed.

Optional Feature:
ISSUE_PERF_CNT_EN:
- Defined: adds outputs perf_stall_cycles[31:0] (+1 each cycle stall=1), perf_flushes[31:0] (+1 per redirect) and perf_issued[31:0] (+1 per accept). All reset to 0 and wrap at 2^32.
- Undefined: these ports and counters are absent and behaviour is otherwise identical.

Decomposition:
- Package issue_pkg: opcode constants (OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC, OP_OP, OP_OPIMM) and the state enum {RUN, HAZARD, FLUSH}.
- Sub-module issue_scoreboard: pending bitmap plus load_cnt, set/clear/bypass logic, exposing pend_eff for three read ports and a full flag.

Test Plan:
- Reset mid-stream: assert reset with ex_valid=1 and pending[5]=1 -> ex_valid=0, pending=0 and load_cnt=0 immediately (async).
- Load-use: issue lw x5,0(x1) then add x6,x5,x2 -> add stalls (stall=1) until wb_valid with wb_rd=5. The add issues in the wb cycle via bypass, so ex_valid=1 on the next edge.
- Queue full (MAX_LOADS=2): issue lw x3 and lw x4, present lw x7 -> stalled. wb_valid (rd=3) arrives in the same cycle as the stall -> lw x7 accepted, load_cnt stays 2.
- Redirect: redirect=1 while if_valid holds lw x9 -> not accepted, pending[9]=0, ex_valid=0 for 2 cycles (redirect + FLUSH), then the next fetch issues.
- WAW and x0: lw x0 accepted with pending unchanged and load_cnt+1. lw x8 followed by addi x8 -> addi stalls until wb_rd=8.
- ISSUE_PERF_CNT_EN: the load-use scenario with a 3-cycle load -> perf_stall_cycles=3, perf_issued=2, perf_flushes=0.

Source files
------------

// File: rtl/issue_pkg.sv
// Shared definitions for the issue/hazard controller.
//   - RV32I major opcode constants
//   - issue FSM state encoding
//   - operand-usage helpers keyed on the major opcode
package issue_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    HAZARD = 2'd1,
    FLUSH  = 2'd2
  } state_e;

  function automatic logic uses_rs1(input logic [6:0] op);
    return !((op == OP_LUI) || (op == OP_AUIPC) || (op == OP_JAL));
  endfunction

  function automatic logic uses_rs2(input logic [6:0] op);
    return (op == OP_OP) || (op == OP_STORE) || (op == OP_BRANCH);
  endfunction

  // Stores and branches are the only formats without a destination.
  function automatic logic writes_rd(input logic [6:0] op);
    return !((op == OP_STORE) || (op == OP_BRANCH));
  endfunction

endpackage

// File: rtl/issue_scoreboard.sv
// Register scoreboard for outstanding variable-latency loads.
// Ports:
//   clk, reset            clock, async active-high reset
//   set_i, set_rd_i       accepted load and its destination (rd=0 counts, never pends)
//   wb_valid_i, wb_rd_i   returning load data
//   rd_a/b/c_i            three lookup registers
//   pend_a/b/c_o          pending with same-cycle writeback bypass applied
//   full_o                load queue full and nothing returning this cycle
module issue_scoreboard
  import issue_pkg::*;
#(
  parameter int MAX_LOADS = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       set_i,
  input  logic [4:0] set_rd_i,
  input  logic       wb_valid_i,
  input  logic [4:0] wb_rd_i,
  input  logic [4:0] rd_a_i,
  input  logic [4:0] rd_b_i,
  input  logic [4:0] rd_c_i,
  output logic       pend_a_o,
  output logic       pend_b_o,
  output logic       pend_c_o,
  output logic       full_o
);

  logic [31:0] pending_q, pending_d;
  logic [2:0]  load_cnt_q, load_cnt_d;
  logic        dec;

  // Register file is write-first, so a returning load unblocks its reader.
  assign pend_a_o = pending_q[rd_a_i] && !(wb_valid_i && (wb_rd_i == rd_a_i));
  assign pend_b_o = pending_q[rd_b_i] && !(wb_valid_i && (wb_rd_i == rd_b_i));
  assign pend_c_o = pending_q[rd_c_i] && !(wb_valid_i && (wb_rd_i == rd_c_i));
  assign full_o   = (load_cnt_q == 3'(MAX_LOADS)) && !wb_valid_i;

  // A writeback with an empty queue is illegal; the count saturates at 0.
  assign dec = wb_valid_i && (load_cnt_q != 3'd0);

  always_comb begin
    pending_d = pending_q;
    if (wb_valid_i) pending_d[wb_rd_i] = 1'b0;
    // Set after clear so a new load to the returning rd stays pending.
    if (set_i) pending_d[set_rd_i] = 1'b1;
    pending_d[0] = 1'b0;

    load_cnt_d = load_cnt_q;
    if (set_i && !dec)      load_cnt_d = load_cnt_q + 3'd1;
    else if (!set_i && dec) load_cnt_d = load_cnt_q - 3'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending_q  <= '0;
      load_cnt_q <= '0;
    end else begin
      pending_q  <= pending_d;
      load_cnt_q <= load_cnt_d;
    end
  end

endmodule

// File: rtl/issue_hazard_ctrl.sv
// Issue controller between fetch and execute: decodes the fetched word,
// stalls on RAW/WAW hazards against outstanding loads or a full load queue,
// drops the wrong-path fetch slot on redirect, and registers the issue slot.
// Ports:
//   clk, reset               clock, async active-high reset
//   if_valid/if_instr        fetch slot; if_ready is combinational accept
//   redirect                 taken branch/jump resolved in execute
//   wb_valid/wb_rd           load data return
//   ex_valid, ex_instr, ex_* registered issue slot and decoded fields
//   stall                    if_valid && !if_ready
// Optional macro ISSUE_PERF_CNT_EN adds perf_stall_cycles, perf_flushes,
// perf_issued (32-bit wrapping counters).
//
// state  | meaning
// RUN    | normal issue
// HAZARD | fetch word held back by scoreboard/queue-full; issues when clear
// FLUSH  | one refill cycle after redirect, nothing accepted
module issue_hazard_ctrl
  import issue_pkg::*;
#(
  parameter int MAX_LOADS = 2,
  parameter int XLEN      = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            if_valid,
  input  logic [XLEN-1:0] if_instr,
  output logic            if_ready,
  input  logic            redirect,
  input  logic            wb_valid,
  input  logic [4:0]      wb_rd,
  output logic            ex_valid,
  output logic [XLEN-1:0] ex_instr,
  output logic [6:0]      ex_opcode,
  output logic [4:0]      ex_rd,
  output logic [2:0]      ex_funct3,
  output logic [4:0]      ex_rs1,
  output logic [4:0]      ex_rs2,
  output logic [6:0]      ex_funct7,
  output logic            stall
`ifdef ISSUE_PERF_CNT_EN
  ,
  output logic [31:0]     perf_stall_cycles,
  output logic [31:0]     perf_flushes,
  output logic [31:0]     perf_issued
`endif
);

  state_e state_q, state_d;

  logic [6:0] opc;
  logic [4:0] rd, rs1, rs2;
  logic       is_load, pend_rs1, pend_rs2, pend_rd, lq_full;
  logic       hazard, accept;

  logic            ex_valid_q;
  logic [XLEN-1:0] ex_instr_q;

  assign opc = if_instr[6:0];
  assign rd  = if_instr[11:7];
  assign rs1 = if_instr[19:15];
  assign rs2 = if_instr[24:20];
  assign is_load = (opc == OP_LOAD);

  issue_scoreboard #(.MAX_LOADS(MAX_LOADS)) u_sb (
    .clk        (clk),
    .reset      (reset),
    .set_i      (accept && is_load),
    .set_rd_i   (rd),
    .wb_valid_i (wb_valid),
    .wb_rd_i    (wb_rd),
    .rd_a_i     (rs1),
    .rd_b_i     (rs2),
    .rd_c_i     (rd),
    .pend_a_o   (pend_rs1),
    .pend_b_o   (pend_rs2),
    .pend_c_o   (pend_rd),
    .full_o     (lq_full)
  );

  assign hazard = (uses_rs1(opc) && pend_rs1)
               || (uses_rs2(opc) && pend_rs2)
               || ((rd != 5'd0) && pend_rd && writes_rd(opc))
               || (is_load && lq_full);

  assign if_ready = (state_q != FLUSH) && !redirect && !hazard;
  assign accept   = if_valid && if_ready;
  assign stall    = if_valid && !if_ready;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN:     if (redirect) state_d = FLUSH;
               else if (if_valid && hazard) state_d = HAZARD;
      HAZARD:  if (redirect) state_d = FLUSH;
               else if (!hazard) state_d = RUN;
      FLUSH:   state_d = redirect ? FLUSH : RUN;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= RUN;
    else       state_q <= state_d;
  end

  // Execute never back-pressures: the slot is a bubble unless refilled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_valid_q <= 1'b0;
      ex_instr_q <= '0;
    end else begin
      ex_valid_q <= accept;
      if (accept) ex_instr_q <= if_instr;
    end
  end

  assign ex_valid  = ex_valid_q;
  assign ex_instr  = ex_instr_q;
  assign ex_opcode = ex_instr_q[6:0];
  assign ex_rd     = ex_instr_q[11:7];
  assign ex_funct3 = ex_instr_q[14:12];
  assign ex_rs1    = ex_instr_q[19:15];
  assign ex_rs2    = ex_instr_q[24:20];
  assign ex_funct7 = ex_instr_q[31:25];

`ifdef ISSUE_PERF_CNT_EN
  logic [31:0] stall_cnt_q, flush_cnt_q, issued_cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_q  <= '0;
      flush_cnt_q  <= '0;
      issued_cnt_q <= '0;
    end else begin
      stall_cnt_q  <= stall_cnt_q  + {31'd0, stall};
      flush_cnt_q  <= flush_cnt_q  + {31'd0, redirect};
      issued_cnt_q <= issued_cnt_q + {31'd0, accept};
    end
  end

  assign perf_stall_cycles = stall_cnt_q;
  assign perf_flushes      = flush_cnt_q;
  assign perf_issued       = issued_cnt_q;
`endif

endmodule

// File: tb/tb_issue_hazard_ctrl.sv
module tb_issue_hazard_ctrl;

  localparam int MAXL = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_valid, if_ready, redirect, wb_valid, ex_valid, stall;
  logic [31:0] if_instr, ex_instr;
  logic [4:0]  wb_rd, ex_rd, ex_rs1, ex_rs2;
  logic [6:0]  ex_opcode, ex_funct7;
  logic [2:0]  ex_funct3;
`ifdef ISSUE_PERF_CNT_EN
  logic [31:0] perf_stall_cycles, perf_flushes, perf_issued;
`endif

  always #5 clk = ~clk;

  issue_hazard_ctrl #(.MAX_LOADS(MAXL), .XLEN(32)) dut (
    .clk(clk), .reset(reset), .if_valid(if_valid), .if_instr(if_instr),
    .if_ready(if_ready), .redirect(redirect), .wb_valid(wb_valid), .wb_rd(wb_rd),
    .ex_valid(ex_valid), .ex_instr(ex_instr), .ex_opcode(ex_opcode), .ex_rd(ex_rd),
    .ex_funct3(ex_funct3), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_funct7(ex_funct7),
    .stall(stall)
`ifdef ISSUE_PERF_CNT_EN
    , .perf_stall_cycles(perf_stall_cycles), .perf_flushes(perf_flushes),
    .perf_issued(perf_issued)
`endif
  );

  int total = 0;
  int bad   = 0;

  // Reference model: list of destination regs of loads still in flight.
  int q[$];
  bit m_flush;

  logic        o_rdy, o_stall, o_val, e_rdy, e_stall, e_val;
  logic [31:0] o_instr, o_fields, e_instr;

  typedef struct {
    logic        v;
    logic [31:0] ins;
    logic        rdr;
    logic        wv;
    logic [4:0]  wr;
    logic        er;
  } step_t;

  function automatic logic [31:0] enc_ld(input int rd, input int rs1);
    logic [4:0] d, s;
    d = 5'(rd); s = 5'(rs1);
    return {12'd0, s, 3'b010, d, 7'b0000011};
  endfunction

  function automatic logic [31:0] enc_add(input int rd, input int rs1, input int rs2);
    logic [4:0] d, s1, s2;
    d = 5'(rd); s1 = 5'(rs1); s2 = 5'(rs2);
    return {7'd0, s2, s1, 3'b000, d, 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_addi(input int rd, input int rs1, input int imm);
    logic [4:0] d, s;
    d = 5'(rd); s = 5'(rs1);
    return {12'(imm), s, 3'b000, d, 7'b0010011};
  endfunction

  function automatic bit m_pend(input int r, input bit wv, input int wr);
    if (r == 0) return 0;
    if (wv && wr == r) return 0;
    foreach (q[i]) if (q[i] == r) return 1;
    return 0;
  endfunction

  function automatic bit m_hazard(input logic [31:0] ins, input bit wv, input int wr);
    logic [6:0] op;
    bit u1, u2, wrd, ld;
    op  = ins[6:0];
    u1  = !(op inside {7'b0110111, 7'b0010111, 7'b1101111});
    u2  = op inside {7'b0110011, 7'b0100011, 7'b1100011};
    wrd = !(op inside {7'b0100011, 7'b1100011});
    ld  = (op == 7'b0000011);
    return (u1 && m_pend(int'(ins[19:15]), wv, wr))
        || (u2 && m_pend(int'(ins[24:20]), wv, wr))
        || (wrd && m_pend(int'(ins[11:7]), wv, wr))
        || (ld && q.size() == MAXL && !wv);
  endfunction

  // One cycle: drive at posedge+1, sample combinational outputs mid-cycle,
  // advance the model, then sample the issue slot at the next posedge+1.
  task automatic cyc(input logic v, input logic [31:0] ins, input logic rdr,
                     input logic wv, input logic [4:0] wr);
    bit acc;
    if_valid = v; if_instr = ins; redirect = rdr; wb_valid = wv; wb_rd = wr;
    #2;
    o_rdy   = if_ready;
    o_stall = stall;
    e_rdy   = !m_flush && !rdr && !m_hazard(ins, wv, int'(wr));
    e_stall = v && !e_rdy;
    acc     = v && e_rdy;
    if (wv) begin
      for (int i = 0; i < q.size(); i++)
        if (q[i] == int'(wr)) begin q.delete(i); break; end
    end
    if (acc && ins[6:0] == 7'b0000011) q.push_back(int'(ins[11:7]));
    m_flush = rdr;
    e_val   = acc;
    if (acc) e_instr = ins;
    @(posedge clk); #1;
    o_val    = ex_valid;
    o_instr  = ex_instr;
    o_fields = {ex_funct7, ex_rs2, ex_rs1, ex_funct3, ex_rd, ex_opcode};
    if_valid = 1'b0; redirect = 1'b0; wb_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    reset = 1'b0;
    q.delete();
    m_flush = 0;
  endtask

  task automatic test_reset();
    total++;
    if (ex_valid !== 1'b0 || ex_instr !== 32'd0 || ex_opcode !== 7'd0) begin
      bad++;
      $display("FAIL reset_state: got valid=%b instr=%h op=%h want 0/0/0", ex_valid, ex_instr, ex_opcode);
    end
    if_valid = 1'b0; if_instr = 32'd0; #1;
    total++;
    if (if_ready !== 1'b1) begin
      bad++; $display("FAIL reset_ready: got %b want 1", if_ready);
    end
    // Fill the queue, then reset between edges.
    cyc(1, enc_ld(5, 1), 0, 0, 0);
    cyc(1, enc_ld(7, 1), 0, 0, 0);
    total++;
    if (o_val !== 1'b1) begin bad++; $display("FAIL reset_pre_valid: got %b want 1", o_val); end
    reset = 1'b1;
    #1;
    total++;
    if (ex_valid !== 1'b0 || ex_instr !== 32'd0) begin
      bad++; $display("FAIL reset_async: got valid=%b instr=%h want 0/0", ex_valid, ex_instr);
    end
    #1;
    reset = 1'b0;
    q.delete(); m_flush = 0;
    // x5 no longer pending and the load count restarted from zero.
    cyc(1, enc_add(6, 5, 2), 0, 0, 0);
    total++;
    if (o_rdy !== 1'b1) begin bad++; $display("FAIL reset_pending_cleared: got %b want 1", o_rdy); end
    cyc(1, enc_ld(3, 1), 0, 0, 0);
    total++;
    if (o_rdy !== 1'b1) begin bad++; $display("FAIL reset_cnt_cleared: got %b want 1", o_rdy); end
    cyc(0, 32'd0, 0, 1, 5'd3);
  endtask

  task automatic test_load_use();
    step_t s[$];
    do_reset();
    s.push_back('{1'b1, enc_ld(5, 1),     1'b0, 1'b0, 5'd0, 1'b1});
    s.push_back('{1'b1, enc_add(6, 5, 2), 1'b0, 1'b0, 5'd0, 1'b0});
    s.push_back('{1'b1, enc_add(6, 5, 2), 1'b0, 1'b0, 5'd0, 1'b0});
    s.push_back('{1'b1, enc_add(6, 5, 2), 1'b0, 1'b1, 5'd5, 1'b1});
    s.push_back('{1'b0, 32'd0,            1'b0, 1'b0, 5'd0, 1'b1});
    foreach (s[i]) begin
      cyc(s[i].v, s[i].ins, s[i].rdr, s[i].wv, s[i].wr);
      total++;
      if (o_rdy !== s[i].er || o_stall !== (s[i].v && !s[i].er)) begin
        bad++; $display("FAIL load_use step %0d: got rdy=%b stall=%b want rdy=%b", i, o_rdy, o_stall, s[i].er);
      end
      total++;
      if (o_val !== (s[i].v && s[i].er) || (o_val && o_instr !== s[i].ins)) begin
        bad++; $display("FAIL load_use_issue step %0d: got v=%b i=%h want v=%b i=%h", i, o_val, o_instr, s[i].v && s[i].er, s[i].ins);
      end
    end
  endtask

  task automatic test_queue_full();
    step_t s[$];
    do_reset();
    s.push_back('{1'b1, enc_ld(3, 1), 1'b0, 1'b0, 5'd0, 1'b1});
    s.push_back('{1'b1, enc_ld(4, 1), 1'b0, 1'b0, 5'd0, 1'b1});
    s.push_back('{1'b1, enc_ld(7, 1), 1'b0, 1'b0, 5'd0, 1'b0});
    s.push_back('{1'b1, enc_ld(7, 1), 1'b0, 1'b1, 5'd3, 1'b1});
    s.push_back('{1'b1, enc_ld(8, 1), 1'b0, 1'b0, 5'd0, 1'b0});
    s.push_back('{1'b1, enc_ld(8, 1), 1'b0, 1'b1, 5'd4, 1'b1});
    s.push_back('{1'b0, 32'd0,        1'b0, 1'b1, 5'd7, 1'b1});
    s.push_back('{1'b0, 32'd0,        1'b0, 1'b1, 5'd8, 1'b1});
    foreach (s[i]) begin
      cyc(s[i].v, s[i].ins, s[i].rdr, s[i].wv, s[i].wr);
      total++;
      if (o_rdy !== s[i].er || o_stall !== (s[i].v && !s[i].er)) begin
        bad++; $display("FAIL queue_full step %0d: got rdy=%b stall=%b want rdy=%b", i, o_rdy, o_stall, s[i].er);
      end
      total++;
      if (o_val !== (s[i].v && s[i].er) || (o_val && o_instr !== s[i].ins)) begin
        bad++; $display("FAIL queue_full_issue step %0d: got v=%b i=%h want v=%b", i, o_val, o_instr, s[i].v && s[i].er);
      end
    end
  endtask

  task automatic test_redirect();
    step_t s[$];
    do_reset();
    s.push_back('{1'b1, enc_ld(9, 1),     1'b1, 1'b0, 5'd0, 1'b0});
    s.push_back('{1'b1, enc_ld(9, 1),     1'b0, 1'b0, 5'd0, 1'b0});
    s.push_back('{1'b1, enc_add(6, 9, 9), 1'b0, 1'b0, 5'd0, 1'b1});
    s.push_back('{1'b1, enc_ld(2, 1),     1'b1, 1'b0, 5'd0, 1'b0});
    s.push_back('{1'b1, enc_ld(2, 1),     1'b1, 1'b0, 5'd0, 1'b0});
    s.push_back('{1'b1, enc_ld(2, 1),     1'b0, 1'b0, 5'd0, 1'b0});
    s.push_back('{1'b1, enc_add(1, 2, 2), 1'b0, 1'b0, 5'd0, 1'b1});
    s.push_back('{1'b0, 32'd0,            1'b0, 1'b0, 5'd0, 1'b1});
    foreach (s[i]) begin
      cyc(s[i].v, s[i].ins, s[i].rdr, s[i].wv, s[i].wr);
      total++;
      if (o_rdy !== s[i].er || o_stall !== (s[i].v && !s[i].er)) begin
        bad++; $display("FAIL redirect step %0d: got rdy=%b stall=%b want rdy=%b", i, o_rdy, o_stall, s[i].er);
      end
      total++;
      if (o_val !== (s[i].v && s[i].er) || (o_val && o_instr !== s[i].ins)) begin
        bad++; $display("FAIL redirect_issue step %0d: got v=%b i=%h want v=%b", i, o_val, o_instr, s[i].v && s[i].er);
      end
    end
  endtask

  task automatic test_waw_x0();
    step_t s[$];
    do_reset();
    s.push_back('{1'b1, enc_ld(0, 1),       1'b0, 1'b0, 5'd0, 1'b1});
    s.push_back('{1'b1, enc_ld(8, 1),       1'b0, 1'b0, 5'd0, 1'b1});
    s.push_back('{1'b1, enc_ld(10, 1),      1'b0, 1'b0, 5'd0, 1'b0});
    s.push_back('{1'b1, enc_add(1, 0, 0),   1'b0, 1'b0, 5'd0, 1'b1});
    s.push_back('{1'b1, enc_addi(8, 1, 1),  1'b0, 1'b0, 5'd0, 1'b0});
    s.push_back('{1'b1, enc_addi(8, 1, 1),  1'b0, 1'b1, 5'd8, 1'b1});
    s.push_back('{1'b0, 32'd0,              1'b0, 1'b1, 5'd0, 1'b1});
    s.push_back('{1'b1, enc_ld(10, 1),      1'b0, 1'b0, 5'd0, 1'b1});
    s.push_back('{1'b0, 32'd0,              1'b0, 1'b1, 5'd10, 1'b1});
    foreach (s[i]) begin
      cyc(s[i].v, s[i].ins, s[i].rdr, s[i].wv, s[i].wr);
      total++;
      if (o_rdy !== s[i].er || o_stall !== (s[i].v && !s[i].er)) begin
        bad++; $display("FAIL waw_x0 step %0d: got rdy=%b stall=%b want rdy=%b", i, o_rdy, o_stall, s[i].er);
      end
      total++;
      if (o_val !== (s[i].v && s[i].er) || (o_val && o_instr !== s[i].ins)) begin
        bad++; $display("FAIL waw_x0_issue step %0d: got v=%b i=%h want v=%b", i, o_val, o_instr, s[i].v && s[i].er);
      end
    end
  endtask

`ifdef ISSUE_PERF_CNT_EN
  task automatic test_perf();
    do_reset();
    cyc(1, enc_ld(5, 1), 0, 0, 0);
    repeat (3) cyc(1, enc_add(6, 5, 2), 0, 0, 0);
    cyc(1, enc_add(6, 5, 2), 0, 1, 5'd5);
    cyc(0, 32'd0, 0, 0, 0);
    total++;
    if (perf_stall_cycles !== 32'd3 || perf_issued !== 32'd2 || perf_flushes !== 32'd0) begin
      bad++;
      $display("FAIL perf: got stall=%0d issued=%0d flush=%0d want 3/2/0", perf_stall_cycles, perf_issued, perf_flushes);
    end
    cyc(1, enc_ld(4, 1), 1, 0, 0);
    cyc(0, 32'd0, 0, 0, 0);
    total++;
    if (perf_flushes !== 32'd1 || perf_stall_cycles !== 32'd4) begin
      bad++; $display("FAIL perf_flush: got flush=%0d stall=%0d want 1/4", perf_flushes, perf_stall_cycles);
    end
  endtask
`endif

  task automatic test_random();
    logic [6:0] ops[9];
    logic [31:0] ins;
    logic v, rdr, wv;
    logic [4:0] wr;
    ops = '{7'b0000011, 7'b0100011, 7'b1100011, 7'b1101111, 7'b1100111,
            7'b0110111, 7'b0010111, 7'b0110011, 7'b0010011};
    do_reset();
    for (int n = 0; n < 600; n++) begin
      ins = $urandom;
      ins[6:0]   = ops[$urandom_range(8, 0)];
      ins[11:7]  = 5'($urandom_range(7, 0));
      ins[19:15] = 5'($urandom_range(7, 0));
      ins[24:20] = 5'($urandom_range(7, 0));
      v   = ($urandom_range(3, 0) != 0);
      rdr = ($urandom_range(15, 0) == 0);
      wv  = 1'b0; wr = 5'd0;
      if (q.size() > 0 && $urandom_range(2, 0) == 0) begin
        wv = 1'b1;
        wr = 5'(q[$urandom_range(q.size() - 1, 0)]);
      end
      cyc(v, ins, rdr, wv, wr);
      total++;
      if (o_rdy !== e_rdy || o_stall !== e_stall) begin
        bad++; $display("FAIL rand_ready cyc %0d: got rdy=%b stall=%b want rdy=%b stall=%b", n, o_rdy, o_stall, e_rdy, e_stall);
      end
      total++;
      if (o_val !== e_val || (e_val && (o_instr !== e_instr || o_fields !== e_instr))) begin
        bad++; $display("FAIL rand_issue cyc %0d: got v=%b i=%h f=%h want v=%b i=%h", n, o_val, o_instr, o_fields, e_val, e_instr);
      end
    end
  endtask

  initial begin
    reset = 1'b1; if_valid = 1'b0; if_instr = 32'd0; redirect = 1'b0;
    wb_valid = 1'b0; wb_rd = 5'd0; m_flush = 0; e_instr = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    test_reset();
    test_load_use();
    test_queue_full();
    test_redirect();
    test_waw_x0();
`ifdef ISSUE_PERF_CNT_EN
    test_perf();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
